// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch/decode boundary
package cpu_pkg;

    // One buffered fetch result: PC, instruction word, fetch address-error flag
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch-to-decode instruction queue with one-cycle flush
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_instr,
    input  logic                     in_adel,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_instr,
    output logic                     out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push;
    logic            pop;

    // Handshake flags come only from registered occupancy, so a pop never frees a slot in the same cycle
    assign in_ready  = (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign count     = cnt_q;

    // Flush wins over both sides of the handshake
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_entry.pc    = 32'(in_pc);
    assign wr_entry.instr = 32'(in_instr);
    assign wr_entry.adel  = in_adel;

    // Next pointer and occupancy; pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer, occupancy and storage registers; reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end
    end

    // Head entry to decode; an empty queue presents a NOP with no address error
    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_pc    = '0;
        out_instr = WIDTH'(NOP_INSTR);
        out_adel  = 1'b0;
        if (out_valid) begin
            out_pc    = WIDTH'(head.pc);
            out_instr = WIDTH'(head.instr);
            out_adel  = head.adel;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam logic [31:0] BASE = 32'hbfc0_0000;
    localparam logic [31:0] IMIX = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_adel = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t exp_out_q[$];
    fetch_entry_t got_q[$];
    int mcnt = 0;

    fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_adel   (in_adel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_adel  (out_adel),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock: model the handshake, record popped heads, land 1 time unit after the edge
    task automatic step();
        bit push, pop;
        fetch_entry_t e;
        push = in_valid && (mcnt != 4) && !flush;
        pop  = (mcnt != 0) && out_ready && !flush;
        if (pop) begin
            e.pc = out_pc; e.instr = out_instr; e.adel = out_adel;
            got_q.push_back(e);
            exp_out_q.push_back(exp_q.pop_front());
        end
        if (flush) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            if (push) begin
                e.pc = in_pc; e.instr = in_instr; e.adel = in_adel;
                exp_q.push_back(e);
            end
            mcnt = mcnt + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic adel);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = pc ^ IMIX;
        in_adel  = adel;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        drive(BASE + 32'h40, 1'b0); step();
        drive(BASE + 32'h44, 1'b0); step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pre_reset_count got=%0d want=2", count); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL midreset_count got=%0d want=0", count); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL midreset_out_instr got=%h want=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL midreset_out_pc got=%h want=0", out_pc); end
        exp_q.delete(); exp_out_q.delete(); got_q.delete(); mcnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        fetch_entry_t g, e;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid got=%b want=0", out_valid); end
        drive(BASE, 1'b0); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid got=%b want=1", out_valid); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count0 got=%0d want=1", count); end
        for (int k = 1; k < 3; k++) begin
            drive(BASE + 32'(4 * k), 1'b0); step();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count%0d got=%0d want=1", k, count); end
        end
        in_valid = 1'b0; step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drained got=%0d want=0", count); end
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL stream_pops got=%0d want=3", got_q.size()); end
        for (int k = 0; got_q.size() > 0; k++) begin
            g = got_q.pop_front(); e = exp_out_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL stream_sb%0d got=%h want=%h", k, g, e); end
            checks++; if (g.pc !== BASE + 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d got=%h want=%h", k, g.pc, BASE + 32'(4 * k)); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        int idx = 0;
        bit acc;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(BASE + 32'(4 * idx), 1'b0);
            acc = (mcnt != 4);
            step();
            if (acc) idx++;
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d want=4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
        checks++; if (out_pc !== BASE) begin errors++; $display("FAIL fill_head got=%h want=%h", out_pc, BASE); end
    endtask

    task automatic test_full_pop();
        fetch_entry_t g, e;
        out_ready = 1'b1;
        step();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got=%0d want=3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_in_ready got=%b want=1", in_ready); end
        out_ready = 1'b0;
        step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL held_push_count got=%0d want=4", count); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drain_count got=%0d want=0", count); end
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL fill_pops got=%0d want=5", got_q.size()); end
        for (int k = 0; got_q.size() > 0; k++) begin
            g = got_q.pop_front(); e = exp_out_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL fill_sb%0d got=%h want=%h", k, g, e); end
            checks++; if (g.pc !== BASE + 32'(4 * k)) begin errors++; $display("FAIL fill_pc%0d got=%h want=%h", k, g.pc, BASE + 32'(4 * k)); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(BASE + 32'h100 + 32'(4 * k), 1'b0); step();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d want=3", count); end
        flush = 1'b1; out_ready = 1'b1;
        drive(32'hdead_beec, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL flush_nop got=%h want=0", out_instr); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got=%b want=0", out_valid); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL flush_pops got=%0d want=0", got_q.size()); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_adel();
        fetch_entry_t g, e;
        logic [31:0] pc;
        logic [31:0] want_pc;
        int sent = 0;
        int cyc = 0;
        bit acc;
        while ((sent < 9 || mcnt != 0) && cyc < 80) begin
            if (sent < 9) begin
                pc = (sent == 5) ? BASE + 32'h16 : BASE + 32'(4 * sent);
                drive(pc, sent == 5);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (cyc % 3) != 0;
            acc = in_valid && (mcnt != 4);
            step();
            if (acc) sent++;
            cyc++;
            checks++; if (count !== 3'(mcnt)) begin errors++; $display("FAIL wrap_count c%0d got=%0d want=%0d", cyc, count, mcnt); end
        end
        checks++; if (cyc >= 80) begin errors++; $display("FAIL wrap_timeout got=%0d cycles want<80", cyc); end
        checks++; if (got_q.size() != 9) begin errors++; $display("FAIL wrap_pops got=%0d want=9", got_q.size()); end
        for (int k = 0; got_q.size() > 0; k++) begin
            g = got_q.pop_front(); e = exp_out_q.pop_front();
            want_pc = (k == 5) ? BASE + 32'h16 : BASE + 32'(4 * k);
            checks++; if (g !== e) begin errors++; $display("FAIL wrap_sb%0d got=%h want=%h", k, g, e); end
            checks++; if (g.pc !== want_pc) begin errors++; $display("FAIL wrap_pc%0d got=%h want=%h", k, g.pc, want_pc); end
            checks++; if (g.adel !== (k == 5)) begin errors++; $display("FAIL wrap_adel%0d got=%b want=%b", k, g.adel, k == 5); end
            checks++; if (g.instr !== (want_pc ^ IMIX)) begin errors++; $display("FAIL wrap_instr%0d got=%h want=%h", k, g.instr, want_pc ^ IMIX); end
        end
        in_valid = 1'b0; in_adel = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill();
        test_full_pop();
        test_flush();
        test_wrap_adel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small in-order instruction queue between the instruction-fetch stage and the decode stage.
- Buffers {PC, instruction, fetch address-error flag} entries produced by fetch.
- Presents the oldest entry to decode through a valid/ready handshake, which decouples cache/uncached fetch stalls from decode stalls.
- A flush (branch redirect, exception, ERET) discards every buffered entry in one cycle.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- WIDTH, 32, PC and instruction width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries; highest priority.
- in_valid  in  1  fetch presents a completed instruction this cycle.
- in_pc  in  WIDTH  PC of the presented instruction.
- in_instr  in  WIDTH  instruction word.
- in_adel  in  1  fetch address error (PC[1:0] != 0) for this entry.
- in_ready  out  1  queue can accept an entry this cycle.
- out_valid  out  1  head entry valid for decode.
- out_ready  in  1  decode consumes head this cycle (not stalled).
- out_pc  out  WIDTH  head PC.
- out_instr  out  WIDTH  head instruction.
- out_adel  out  1  head address-error flag.
- count  out  $clog2(DEPTH)+1  current occupancy, for debug/perf.

Behaviour:
- Storage:
  - Circular array of DEPTH entries, write pointer wr_ptr, read pointer rd_ptr.
  - Each pointer is $clog2(DEPTH) bits and wraps modulo DEPTH by natural overflow.
  - Occupancy register cnt drives count.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, cnt=0, all entries cleared to zero. Resulting outputs:
  - out_valid=0, out_pc=0, out_instr=0, out_adel=0.
  - in_ready=1, count=0.
- in_ready = (cnt != DEPTH).
  - Purely from registered state; no combinational path from out_ready.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- push = in_valid && in_ready && !flush. pop = out_valid && out_ready && !flush.
- On push: the entry is written at wr_ptr and wr_ptr increments.
- On pop: rd_ptr increments.
- cnt update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Latency: no bypass. An entry pushed at edge N is visible with out_valid=1 from after edge N.
  - Minimum fetch-to-decode latency is 1 cycle.
  - Sustained throughput is 1 entry/cycle whenever cnt is between 1 and DEPTH-1.
- Outputs:
  - out_valid = (cnt != 0).
  - out_pc, out_instr, out_adel = entry[rd_ptr] when out_valid, else 0.
  - An empty queue therefore presents a NOP (32'h0).
- flush=1 at an edge:
  - wr_ptr <= 0, rd_ptr <= 0, cnt <= 0.
  - Push and pop in that cycle are ignored.
  - Entry contents need not be cleared.
  - The next cycle shows out_valid=0 and in_ready=1.
- in_valid while full: the entry is not accepted. Fetch must hold in_pc/in_instr until in_ready=1. The queue never drops or overwrites an entry.
- out_ready while empty: no effect; cnt never underflows.
- Wrap-around: after DEPTH pushes, wr_ptr returns to 0. FIFO ordering is preserved across the wrap.
- Reset asserted mid-operation: all state clears immediately (async) regardless of in_valid, out_ready or flush.

Decomposition:
- Shared package (cpu_pkg):
  - fetch_entry_t packed struct {pc[31:0], instr[31:0], adel}.
  - NOP_INSTR = 32'h0.
  - RESET_VECTOR = 32'hbfc0_0000, for use by neighbouring stages.
- No sub-module. Storage is an internal array of fetch_entry_t, with pointer/count logic in the same module.

Test Plan:
- Reset then idle: assert rst mid-cycle, no clk edge -> out_valid=0, in_ready=1, count=0, out_instr=0 immediately.
- Streaming: push PCs 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles with out_ready=1 -> out_valid rises one cycle after the first push; decode sees the three PCs in order, one per cycle; count stays at 1.
- Fill/full: out_ready=0, push 5 entries -> first 4 accepted, count=4, in_ready=0. The 5th (PC 0xbfc00010) is held by fetch and is accepted only after one pop. Order 0xbfc00000..0xbfc00010 is preserved.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop only; count=3; in_ready=1 next cycle.
- Flush priority: count=3, with flush=1, in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0. The pushed entry is never output.
- Wrap and adel: push/pop 9 entries through DEPTH=4 with entry 6 having in_adel=1 (PC 0xbfc00016) -> outputs are in order across the pointer wrap; out_adel=1 only with PC 0xbfc00016.
